// File: rtl/adder_tree_accum_ctrl.sv
// Window reducer: packs a stream of terms into four slots, fires a shared
// 4-input adder tree once per group and accumulates the window total.

module adder_tree #(
  parameter int WIDTH = 13
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] tree_sum
);
  logic [WIDTH-1:0] ab;
  logic [WIDTH-1:0] cd;

  assign ab       = a + b;
  assign cd       = c + d;
  assign tree_sum = ab + cd;
endmodule

module adder_tree_accum_ctrl #(
  parameter int WIDTH = 13,
  parameter int TERMS = 9,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             busy
);
  typedef enum logic [1:0] {FILL, ADD, DONE} state_t;

  localparam logic [CNT_W-1:0] TERMS_C = CNT_W'(TERMS);

  state_t           state;
  logic [WIDTH-1:0] a, b, c, d;
  logic [WIDTH-1:0] tree_sum;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [1:0]       slot_idx;
  logic [CNT_W-1:0] term_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             accept;

  adder_tree #(.WIDTH(WIDTH)) u_tree (
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .tree_sum (tree_sum)
  );

  assign accept  = in_valid && in_ready;
  assign cnt_nxt = term_cnt + CNT_W'(1);
  assign acc_nxt = acc + tree_sum;

  // in_ready is registered, so it is low while reset is held and rises on
  // the first clock afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      d         <= '0;
      slot_idx  <= '0;
      term_cnt  <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            case (slot_idx)
              2'd0:    a <= in_data;
              2'd1:    b <= in_data;
              2'd2:    c <= in_data;
              default: d <= in_data;
            endcase
            slot_idx <= slot_idx + 2'd1;
            term_cnt <= cnt_nxt;
            busy     <= 1'b1;
            if (slot_idx == 2'd3 || cnt_nxt == TERMS_C) begin
              state    <= ADD;
              in_ready <= 1'b0;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        ADD: begin
          // Unfilled slots are still zero, so a short last group is padded.
          acc      <= acc_nxt;
          a        <= '0;
          b        <= '0;
          c        <= '0;
          d        <= '0;
          slot_idx <= '0;
          if (term_cnt == TERMS_C) begin
            state     <= DONE;
            out_sum   <= acc_nxt;
            out_valid <= 1'b1;
          end else begin
            state    <= FILL;
            in_ready <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            term_cnt  <= '0;
            busy      <= 1'b0;
            state     <= FILL;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state    <= FILL;
          in_ready <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/adder_tree_accum_ctrl.md
Name: adder_tree_accum_ctrl

Overview:
Sequencer that time-shares one 4-input adder_tree instance to reduce a kernel window of TERMS values (e.g. 9 terms for a 3x3 kernel) to a single sum. It accepts one term per cycle over a valid/ready stream and packs terms into four operand slots. It fires the tree once per group of four, accumulates the partial sums, and presents the window total on an output valid/ready stream. It sits between the product generator and the activation/output stage of the convolution datapath.

Parameters:
WIDTH, 13, data width of terms, partial sums and the accumulator; must match the adder_tree width.
TERMS, 9, terms per output sum; legal range is 1 to 255.
CNT_W, 8, width of the term counter; must satisfy 2^CNT_W > TERMS.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  in_data holds a term.
in_ready  out  1  block can accept a term this cycle.
in_data  in  WIDTH  term value (unsigned).
out_valid  out  1  out_sum holds a completed window sum.
out_ready  in  1  consumer takes out_sum this cycle.
out_sum  out  WIDTH  window sum, modulo 2^WIDTH.
busy  out  1  high from the first accepted term of a window until the output handshake.

Behaviour:
- Reset (asynchronous, applied immediately): state=FILL; slots a, b, c, d = 0; slot_idx=0; term_cnt=0; acc=0; out_valid=0; out_sum=0; busy=0. in_ready=1 from the first clock after reset deassertion.
- Internal: one combinational adder_tree(a, b, c, d, tree_sum); tree_sum is WIDTH bits and wraps modulo 2^WIDTH.
- FSM states are FILL, ADD and DONE.
- FILL:
  - in_ready=1.
  - On in_valid&&in_ready: slot[slot_idx] <= in_data; slot_idx++; term_cnt++; busy <= 1.
  - Go to ADD on the accept that fills slot 3, or on the accept that makes term_cnt == TERMS, whichever comes first.
  - Cycles without in_valid: no state change. in_data is ignored.
- ADD (always exactly 1 cycle):
  - in_ready=0.
  - acc <= acc + tree_sum, truncated to WIDTH bits. Unfilled slots are 0, so a partial final group is zero-padded.
  - Clear slots to 0 and set slot_idx=0.
  - If term_cnt == TERMS, go to DONE and load out_sum <= acc + tree_sum. Otherwise go back to FILL.
- DONE:
  - out_valid=1 and in_ready=0.
  - out_sum is held stable while out_ready=0.
  - On out_ready: out_valid <= 0; acc, term_cnt and busy <= 0; go to FILL. The next window can be accepted on the following cycle.
  - There is never overlap between windows: no term is accepted while out_valid=1.
- Latency with TERMS=9, continuous input and out_ready=1:
  - Accepts at cycles 0–3, ADD at 4.
  - Accepts at 5–8, ADD at 9.
  - Accept at 10, ADD at 11.
  - out_valid high at cycle 12 for one cycle.
  - General form: TERMS + ceil(TERMS/4) cycles from the first accept to out_valid.
- TERMS=1: every window is one accept, one ADD with slots b, c, d = 0, then DONE; out_sum equals in_data.
- TERMS a multiple of 4: the final ADD has all slots filled, with no padding.
- Reset mid-window discards all partial data. The next window starts from acc=0 with no residue.
- Arithmetic is unsigned modulo 2^WIDTH with no saturation and no overflow flag.

Test Plan:
- Reset: assert rst for 3 cycles, then release -> out_valid=0, out_sum=0, busy=0; in_ready=1 on the first post-reset clock.
- TERMS=9, in_data=1..9 on consecutive cycles, out_ready=1 -> in_ready low at cycles 4, 9 and 11; out_valid high only at cycle 12; out_sum=45.
- Overflow: nine terms of 13'h1FFF -> out_sum=13'h1FF7 (73719 mod 8192 = 8183).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises, with in_valid=1 and in_data=7 -> out_valid and out_sum stay stable and in_ready=0. After the handshake, nine 7s give out_sum=63, with no term from the stall window counted.
- Input gaps: terms 3,0,5,2,4,1,6,8,9 with in_valid toggled every other cycle -> ADD fires only after the 4th and 8th accepts and the 9th term; out_sum=38.
- Reset mid-window: pulse rst asynchronously (between clock edges) after 6 accepted terms of 100, then feed nine terms of 1 -> out_sum=9.
